// File: rtl/cic_comb_dec_if.sv
// Sample stream bundle for the CIC comb section: integrator samples in, decimated samples out.
// master = producer/consumer side, slave = the comb block.
interface cic_comb_dec_if #(
   parameter int DW = 26
);
   logic          din_valid;
   logic [DW-1:0] din;
   logic          dout_valid;
   logic [DW-1:0] dout;

   modport master (
      output din_valid,
      output din,
      input  dout_valid,
      input  dout
   );

   modport slave (
      input  din_valid,
      input  din,
      output dout_valid,
      output dout
   );
endinterface

// File: rtl/cic_comb_dec.sv
// Decimating comb section of a CIC decimator: keeps every R-th valid sample and runs N first-difference stages.
// Optional macro COMB_PIPE_EN registers every comb stage (latency N); otherwise one output register (latency 1).
module cic_comb_dec #(
   parameter int DW = 26,
   parameter int N  = 3,
   parameter int R  = 8
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           sync_clr,
   cic_comb_dec_if.slave  bus
);
   localparam int            CW       = (R > 1) ? $clog2(R) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(R - 1);

   logic [CW-1:0] cnt;
   logic          dstb;
   logic [DW-1:0] d [N];

   // Clear wins over a valid sample in the same cycle, so that sample is never kept.
   assign dstb = bus.din_valid && !sync_clr && (cnt == CNT_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (sync_clr) begin
         cnt <= '0;
      end else if (bus.din_valid) begin
         cnt <= dstb ? '0 : cnt + 1'b1;
      end
   end

`ifdef COMB_PIPE_EN
   logic [DW-1:0] s [N];
   logic [N-1:0]  v;
   logic [DW-1:0] pin [N];
   logic [N-1:0]  pv;

   always_comb begin
      pin[0] = bus.din;
      pv[0]  = dstb;
      for (int k = 1; k < N; k++) begin
         pin[k] = s[k-1];
         pv[k]  = v[k-1];
      end
   end

   // Last stage data is dout itself and holds across a clear; only its valid bit drops.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v <= '0;
         for (int k = 0; k < N; k++) begin
            s[k] <= '0;
            d[k] <= '0;
         end
      end else if (sync_clr) begin
         v <= '0;
         for (int k = 0; k < N; k++) begin
            d[k] <= '0;
         end
         for (int k = 0; k < N - 1; k++) begin
            s[k] <= '0;
         end
      end else begin
         v <= pv;
         for (int k = 0; k < N; k++) begin
            if (pv[k]) begin
               s[k] <= pin[k] - d[k];
               d[k] <= pin[k];
            end
         end
      end
   end

   assign bus.dout       = s[N-1];
   assign bus.dout_valid = v[N-1];
`else
   logic [DW-1:0] sin [N];
   logic [DW-1:0] acc;
   logic [DW-1:0] dout_r;
   logic          dv_r;

   always_comb begin
      acc = bus.din;
      for (int k = 0; k < N; k++) begin
         sin[k] = acc;
         acc    = acc - d[k];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dout_r <= '0;
         dv_r   <= 1'b0;
         for (int k = 0; k < N; k++) begin
            d[k] <= '0;
         end
      end else if (sync_clr) begin
         dv_r <= 1'b0;
         for (int k = 0; k < N; k++) begin
            d[k] <= '0;
         end
      end else begin
         dv_r <= dstb;
         if (dstb) begin
            dout_r <= acc;
            for (int k = 0; k < N; k++) begin
               d[k] <= sin[k];
            end
         end
      end
   end

   assign bus.dout       = dout_r;
   assign bus.dout_valid = dv_r;
`endif
endmodule

// File: tb/tb_cic_comb_dec.sv
// Scoreboard bench for cic_comb_dec; expected latency follows COMB_PIPE_EN.
module tb_cic_comb_dec;
   localparam int DW = 26;
   localparam int N  = 3;
   localparam int R  = 8;
`ifdef COMB_PIPE_EN
   localparam int LAT = N;
`else
   localparam int LAT = 1;
`endif

   typedef struct {
      logic [DW-1:0] val;
      int            due;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic sync_clr = 1'b0;

   cic_comb_dec_if #(.DW(DW)) bus ();

   cic_comb_dec #(.DW(DW), .N(N), .R(R)) dut (
      .clk      (clk),
      .rst      (rst),
      .sync_clr (sync_clr),
      .bus      (bus)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int total = 0;
   int bad   = 0;

   exp_t          sb [$];
   logic [DW-1:0] obs_val [$];
   int            obs_cyc [$];

   int            m_cnt = 0;
   logic [DW-1:0] m_d [N];

   task automatic model_reset();
      m_cnt = 0;
      for (int k = 0; k < N; k++) m_d[k] = '0;
   endtask

   // Drive one cycle of stimulus and advance the reference model.
   task automatic drive(input logic v, input logic [DW-1:0] data, input logic clr);
      logic [DW-1:0] x;
      logic [DW-1:0] y;
      if (clr) begin
         model_reset();
         while (sb.size() > 0 && sb[sb.size()-1].due > cyc) void'(sb.pop_back());
      end else if (v) begin
         if (m_cnt == R - 1) begin
            m_cnt = 0;
            x = data;
            for (int k = 0; k < N; k++) begin
               y = x - m_d[k];
               m_d[k] = x;
               x = y;
            end
            sb.push_back('{x, cyc + LAT});
         end else begin
            m_cnt++;
         end
      end
      bus.din_valid = v;
      bus.din       = data;
      sync_clr      = clr;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, '0, 1'b0);
   endtask

   task automatic clear_obs();
      obs_val.delete();
      obs_cyc.delete();
   endtask

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (bus.dout_valid) begin
               total++;
               obs_val.push_back(bus.dout);
               obs_cyc.push_back(cyc);
               if (sb.size() == 0) begin
                  bad++;
                  $display("FAIL unexpected_strobe cyc=%0d dout=%h", cyc, bus.dout);
               end else begin
                  e = sb.pop_front();
                  if (bus.dout !== e.val || cyc !== e.due) begin
                     bad++;
                     $display("FAIL sb_output got=%h@%0d want=%h@%0d", bus.dout, cyc, e.val, e.due);
                  end
               end
            end else if (sb.size() > 0 && sb[0].due <= cyc) begin
               total++;
               bad++;
               $display("FAIL missing_strobe cyc=%0d want=%h@%0d", cyc, sb[0].val, sb[0].due);
               void'(sb.pop_front());
            end
         end
      end
   end

   task automatic test_reset();
      repeat (3) @(posedge clk);
      #1;
      total += 2;
      if (bus.dout !== '0) begin
         bad++;
         $display("FAIL reset_dout got=%h want=0", bus.dout);
      end
      if (bus.dout_valid !== 1'b0) begin
         bad++;
         $display("FAIL reset_dout_valid got=%b want=0", bus.dout_valid);
      end
      rst = 1'b0;
      model_reset();
   endtask

   task automatic test_ramp();
      logic [DW-1:0] want [5];
      want = '{26'd8, 26'h3FFFFF8, 26'd0, 26'd0, 26'd0};
      drive(1'b0, '0, 1'b1);
      clear_obs();
      for (int i = 1; i <= 40; i++) drive(1'b1, DW'(i), 1'b0);
      idle(LAT + 2);
      total++;
      if (obs_val.size() != 5) begin
         bad++;
         $display("FAIL ramp_count got=%0d want=5", obs_val.size());
      end else begin
         for (int i = 0; i < 5; i++) begin
            total++;
            if (obs_val[i] !== want[i]) begin
               bad++;
               $display("FAIL ramp_val[%0d] got=%h want=%h", i, obs_val[i], want[i]);
            end
         end
      end
   endtask

   task automatic test_wrap();
      logic [DW-1:0] want [6];
      want = '{26'h3FFFFF7, 26'h000001A, 26'h3FFFFEF, 26'd0, 26'd0, 26'd0};
      drive(1'b0, '0, 1'b1);
      clear_obs();
      for (int i = 0; i < 48; i++) drive(1'b1, 26'h3FFFFF0 + DW'(i), 1'b0);
      idle(LAT + 2);
      total++;
      if (obs_val.size() != 6) begin
         bad++;
         $display("FAIL wrap_count got=%0d want=6", obs_val.size());
      end else begin
         for (int i = 0; i < 6; i++) begin
            total++;
            if (obs_val[i] !== want[i]) begin
               bad++;
               $display("FAIL wrap_val[%0d] got=%h want=%h", i, obs_val[i], want[i]);
            end
         end
      end
   endtask

   task automatic test_gapped();
      logic [DW-1:0] want [5];
      want = '{26'd8, 26'h3FFFFF8, 26'd0, 26'd0, 26'd0};
      drive(1'b0, '0, 1'b1);
      clear_obs();
      for (int i = 1; i <= 40; i++) begin
         drive(1'b1, DW'(i), 1'b0);
         drive(1'b0, '0, 1'b0);
      end
      idle(LAT + 2);
      total++;
      if (obs_val.size() != 5) begin
         bad++;
         $display("FAIL gap_count got=%0d want=5", obs_val.size());
      end else begin
         for (int i = 0; i < 5; i++) begin
            total++;
            if (obs_val[i] !== want[i]) begin
               bad++;
               $display("FAIL gap_val[%0d] got=%h want=%h", i, obs_val[i], want[i]);
            end
         end
         for (int i = 1; i < 5; i++) begin
            total++;
            if (obs_cyc[i] - obs_cyc[i-1] != 16) begin
               bad++;
               $display("FAIL gap_spacing[%0d] got=%0d want=16", i, obs_cyc[i] - obs_cyc[i-1]);
            end
         end
      end
   endtask

   task automatic test_clear();
      drive(1'b0, '0, 1'b1);
      clear_obs();
      for (int i = 1; i <= 7; i++) drive(1'b1, DW'(100 + i), 1'b0);
      drive(1'b1, DW'(108), 1'b1);
      idle(LAT + 2);
      total++;
      if (obs_val.size() != 0) begin
         bad++;
         $display("FAIL clr_no_output got=%0d want=0", obs_val.size());
      end
      for (int i = 1; i <= 8; i++) drive(1'b1, DW'(200 + i), 1'b0);
      idle(LAT + 2);
      total++;
      if (obs_val.size() != 1 || obs_val[0] !== DW'(208)) begin
         bad++;
         $display("FAIL clr_next got=%0d/%h want=1/%h", obs_val.size(),
                  (obs_val.size() > 0) ? obs_val[0] : '0, DW'(208));
      end
   endtask

   task automatic test_reset_mid();
      drive(1'b0, '0, 1'b1);
      clear_obs();
      for (int i = 1; i <= 8; i++) drive(1'b1, DW'(i), 1'b0);
      rst = 1'b1;
      model_reset();
      sb.delete();
      #1;
      total += 2;
      if (bus.dout !== '0) begin
         bad++;
         $display("FAIL rstmid_dout got=%h want=0", bus.dout);
      end
      if (bus.dout_valid !== 1'b0) begin
         bad++;
         $display("FAIL rstmid_dout_valid got=%b want=0", bus.dout_valid);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      clear_obs();
      idle(LAT + 2);
      for (int i = 0; i < 8; i++) drive(1'b1, DW'(50 + i), 1'b0);
      idle(LAT + 2);
      total++;
      if (obs_val.size() != 1 || obs_val[0] !== DW'(57)) begin
         bad++;
         $display("FAIL rstmid_first got=%0d/%h want=1/%h", obs_val.size(),
                  (obs_val.size() > 0) ? obs_val[0] : '0, DW'(57));
      end
   endtask

   task automatic test_latency();
      int t0;
      drive(1'b0, '0, 1'b1);
      clear_obs();
      for (int i = 0; i < 7; i++) drive(1'b1, '0, 1'b0);
      t0 = cyc;
      drive(1'b1, 26'h0000100, 1'b0);
      idle(LAT + 2);
      total++;
      if (obs_val.size() != 1) begin
         bad++;
         $display("FAIL lat_count got=%0d want=1", obs_val.size());
      end else begin
         total += 2;
         if (obs_val[0] !== 26'h0000100) begin
            bad++;
            $display("FAIL lat_val got=%h want=%h", obs_val[0], 26'h0000100);
         end
         if (obs_cyc[0] - t0 != LAT) begin
            bad++;
            $display("FAIL lat_cycles got=%0d want=%0d", obs_cyc[0] - t0, LAT);
         end
      end
   endtask

   initial begin
      bus.din_valid = 1'b0;
      bus.din       = '0;
      model_reset();
      test_reset();
      test_ramp();
      test_wrap();
      test_gapped();
      test_clear();
      test_reset_mid();
      test_latency();
      idle(4);
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL leftover_expected got=%0d want=0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout cyc=%0d", cyc);
      $fatal(1, "timeout");
   end
endmodule

// File: doc/cic_comb_dec.md
# cic_comb_dec

Decimating comb section of a CIC decimator. It is the counterpart to the 26-bit registered adder/integrator path. The block takes the wrapped two's-complement integrator stream, keeps every R-th valid sample, and passes it through N cascaded first-difference (comb) stages to produce the decimated output. It sits between the integrator chain and the downstream decimated-rate filters.

## Interface
- `DW`, 26, data width of input, internal stages and output (matches integrator width).
- `N`, 3, number of comb stages (1..6).
- `R`, 8, decimation ratio (2..255).
- `clk`  in  1  single system clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `sync_clr`  in  1  synchronous clear of phase counter, delay registers, pipeline and valid flags.
- `din_valid`  in  1  `din` carries a new integrator sample this cycle.
- `din`  in  DW  integrator output, two's complement, modulo 2^DW.
- `dout_valid`  out  1  one-cycle strobe; `dout` holds a new decimated sample.
- `dout`  out  DW  comb output, two's complement, modulo 2^DW.

## Operation
- Phase counter `cnt` has width ceil(log2 R) and resets to 0.
    - On `din_valid` it increments.
    - On `din_valid` with `cnt==R-1` it wraps to 0 and asserts an internal decimate strobe `dstb`.
    - The R-th, 2R-th, ... valid samples are kept; all others are discarded.
- Gaps in `din_valid` are allowed. The counter holds, so decimation counts valid samples, not cycles.
- Comb stage k (k=1..N): `y_k = x_k - d_k`, then `d_k <= x_k`. Here `x_1` is the kept `din` and `x_k = y_(k-1)`.
    - `d_k` updates only when stage k's input is valid.
    - Delay registers reset to 0. The first output is therefore the first kept sample itself.
- Arithmetic is DW-bit modulo 2^DW, with no saturation, rounding or width growth. Wrap-around in `din` is expected and cancels exactly.
- `sync_clr` has priority over `din_valid` in the same cycle. That sample is dropped, `cnt`, all `d_k` and the pipeline are zeroed, and `dout_valid` is forced to 0 next cycle.
    - `dout` keeps its last value.
    - The next kept sample is the R-th valid sample after the clear.
- `rst` asserted mid-operation immediately zeroes all state, including in-flight pipeline samples. No partial output is produced.
- Reset values: `dout`=0, `dout_valid`=0, `cnt`=0, all `d_k`=0, pipeline valid bits 0.

## Timing
- Without `COMB_PIPE_EN`:
    - The whole comb chain is combinational from `din` to the `dout` register.
    - `dout_valid` is high in the cycle after the edge that samples the kept `din_valid` (latency 1).
    - Maximum throughput is one output per cycle (R≥2 means the input never exceeds 1/2).
- With `COMB_PIPE_EN`:
    - Each stage output is registered and stage N's register is `dout`.
    - A valid bit travels with the data, so latency is N cycles (3 at default).
- `dout_valid` is always exactly one cycle wide. Consecutive outputs are at least R valid inputs apart.
- There is no backpressure. The consumer must accept `dout` on the `dout_valid` cycle.

## Configuration
- `COMB_PIPE_EN` defined: a register after every comb stage, latency N, for closing timing at high clock rates with large N/DW.
- Not defined: single output register, latency 1, fewer flops.
- Numerical results and output ordering are identical in both builds. Only the latency differs, and the bench parameterises its expected latency on the macro.

## Test plan
- Ramp, defaults: `din`=1,2,3,... every cycle with `din_valid`=1. Kept samples are 8,16,24,32,40. Outputs are 8, 0x3FFFFF8 (−8), 0, 0, 0.
- Wrap-around: `din` starts at 0x3FFFFF0 and increments by 1 per cycle. Kept samples are 0x3FFFFF7, 0x3FFFFFF, 0x0000007, 0x000000F, .... Outputs are 0x3FFFFF7, 0x000001A, 0x3FFFFEF, then 0 from the 4th output on, through the wrap.
- Gapped valid: same ramp as the first scenario, with `din_valid` toggling 1/0 each cycle. The output sequence is unchanged and `dout_valid` strobes every 16 cycles.
- Clear priority: assert `sync_clr` together with the 8th `din_valid`. No output is produced. The next output appears after 8 further valid samples and equals that 8th post-clear `din` value.
- Reset mid-run: assert `rst` while a sample is in the pipeline (`COMB_PIPE_EN` build). `dout`/`dout_valid` go to 0 immediately and no stale strobe appears after release. The first post-reset output equals the 8th post-reset sample.
- Latency check: single kept sample 0x0000100. `dout_valid` rises 1 cycle after acceptance without the macro and 3 cycles after with it, with `dout`=0x0000100 in both builds.
